// File: rtl/display_pkg.sv
// Shared constants for the display RAM card-slot region, plus the writer FSM
// state encoding. The VGA controller derives its slot read address from BASE_ADDR.
package display_pkg;

  localparam logic [31:0] BASE_ADDR = 32'd16;
  localparam logic [2:0]  MAX_SLOTS = 3'd7;
  localparam int          CARD_W    = 4;
  localparam logic [CARD_W-1:0] CARD_MAX = 4'd13;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BLANK = 2'd1,
    DRAIN      = 2'd2,
    CLEAR      = 2'd3
  } state_t;

  // Index 0 is reserved for "empty slot", so a real card is 1..CARD_MAX.
  function automatic logic cardValid(input logic [CARD_W-1:0] card);
    return (card != '0) && (card <= CARD_MAX);
  endfunction

endpackage

// File: rtl/deal_fifo.sv
// Small synchronous FIFO buffering deal requests until the next blanking window.
// Push and pop may occur together (also when full); flush empties it at once.
module deal_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wrData,
  output logic [W-1:0]  rdData,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic          doPush;
  logic          doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign rdData = mem[rdPtr];

  // Pointer and occupancy bookkeeping; flush wins over any push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; needs no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/card_slot_writer.sv
// Writer for the card-slot region of the display RAM. Deal requests are
// buffered and only committed (or the hand zero-filled) right after a
// screenEnd pulse, so a frame never shows a half-updated hand.
//
// Handshake: a deal beat transfers on the rising clk edge where
// dealValid && dealReady are both high; dealReady never depends on dealValid.
module card_slot_writer
  import display_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dealValid,
  input  logic [CARD_W-1:0] dealCard,
  output logic              dealReady,
  input  logic              clearReq,
  input  logic              screenEnd,
  output logic [31:0]       memAddr,
  output logic [31:0]       memData,
  output logic              memWEn,
  output logic [2:0]        slotCount,
  output logic              busy,
  output logic              err,
  output logic [1:0]        dbgState
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  state_t            stateNext;
  logic [2:0]        slotCountNext;
  logic [2:0]        clrIdx;
  logic [2:0]        clrIdxNext;
  logic              clearPending;
  logic              clearPendingNext;
  logic              errNext;
  logic [31:0]       memAddrNext;
  logic [31:0]       memDataNext;
  logic              memWEnNext;

  logic              dealAccept;
  logic              fifoPush;
  logic              fifoPop;
  logic              fifoFlush;
  logic [CARD_W-1:0] fifoRdData;
  logic [CW-1:0]     fifoCount;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [3:0]        occupancy;

  // Slots already committed plus slots still queued must stay within the hand.
  assign occupancy  = 4'(slotCount) + 4'(fifoCount);
  assign dealReady  = !clearReq && !clearPending && (state != CLEAR) &&
                      (occupancy < 4'(MAX_SLOTS)) && !fifoFull;
  assign dealAccept = dealValid && dealReady;
  // Invalid cards complete the handshake but are never queued.
  assign fifoPush   = dealAccept && cardValid(dealCard);
  assign fifoFlush  = clearReq;
  assign busy       = (state != IDLE) || clearPending;
  assign dbgState   = state;

  deal_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CARD_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (fifoPush),
    .pop    (fifoPop),
    .flush  (fifoFlush),
    .wrData (dealCard),
    .rdData (fifoRdData),
    .count  (fifoCount),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic and next values for the slot bookkeeping and RAM port.
  always_comb begin
    stateNext        = state;
    slotCountNext    = slotCount;
    clrIdxNext       = clrIdx;
    clearPendingNext = clearPending;
    errNext          = err;
    memAddrNext      = memAddr;
    memDataNext      = memData;
    memWEnNext       = 1'b0;
    fifoPop          = 1'b0;

    if (dealAccept && !cardValid(dealCard)) errNext = 1'b1;

    case (state)
      IDLE: begin
        // Looking at the push too lets a beat catch the very next screenEnd.
        if (!fifoEmpty || fifoPush || clearPending || clearReq) stateNext = WAIT_BLANK;
      end
      WAIT_BLANK: begin
        if (screenEnd) begin
          if (clearPending || clearReq) begin
            stateNext  = CLEAR;
            clrIdxNext = '0;
          end else if (!fifoEmpty) begin
            stateNext = DRAIN;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      DRAIN: begin
        if (clearReq) begin
          // Abandon the rest of the window; the flush drops queued cards.
          stateNext = WAIT_BLANK;
        end else if (!fifoEmpty) begin
          fifoPop     = 1'b1;
          memWEnNext  = 1'b1;
          memAddrNext = BASE_ADDR + 32'(slotCount);
          memDataNext = 32'(fifoRdData);
          if (slotCount < MAX_SLOTS) slotCountNext = slotCount + 3'd1;
          if ((fifoCount == CW'(1)) && !fifoPush) stateNext = IDLE;
        end else begin
          stateNext = IDLE;
        end
      end
      CLEAR: begin
        memWEnNext  = 1'b1;
        memAddrNext = BASE_ADDR + 32'(clrIdx);
        memDataNext = 32'd0;
        if (clrIdx == MAX_SLOTS - 3'd1) begin
          slotCountNext    = '0;
          clearPendingNext = 1'b0;
          errNext          = 1'b0;
          stateNext        = IDLE;
        end else begin
          clrIdxNext = clrIdx + 3'd1;
        end
      end
      default: stateNext = IDLE;
    endcase

    // A new clear request always wins over the end of a previous clear.
    if (clearReq) clearPendingNext = 1'b1;
  end

  // Registered datapath; reset leaves a pending clear so the first blank zero-fills.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slotCount    <= '0;
      clrIdx       <= '0;
      clearPending <= 1'b1;
      err          <= 1'b0;
      memAddr      <= '0;
      memData      <= '0;
      memWEn       <= 1'b0;
    end else begin
      slotCount    <= slotCountNext;
      clrIdx       <= clrIdxNext;
      clearPending <= clearPendingNext;
      err          <= errNext;
      memAddr      <= memAddrNext;
      memData      <= memDataNext;
      memWEn       <= memWEnNext;
    end
  end

endmodule

// File: tb/tb_card_slot_writer.sv
// Self-checking bench for card_slot_writer: a transaction-level hand model
// predicts every RAM write, the slot count, err and dealReady.
module tb_card_slot_writer;
  import display_pkg::*;

  localparam int M_BASE  = 16;
  localparam int M_SLOTS = 7;
  localparam int M_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dealValid = 1'b0;
  logic [3:0]  dealCard = '0;
  logic        clearReq = 1'b0;
  logic        screenEnd = 1'b0;
  logic        dealReady;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        memWEn;
  logic [2:0]  slotCount;
  logic        busy;
  logic        err;
  logic [1:0]  dbgState;

  card_slot_writer dut (
    .clk       (clk),
    .reset     (reset),
    .dealValid (dealValid),
    .dealCard  (dealCard),
    .dealReady (dealReady),
    .clearReq  (clearReq),
    .screenEnd (screenEnd),
    .memAddr   (memAddr),
    .memData   (memData),
    .memWEn    (memWEn),
    .slotCount (slotCount),
    .busy      (busy),
    .err       (err),
    .dbgState  (dbgState)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected RAM writes: {addr, data}.
  logic [63:0] exp_q[$];
  logic [63:0] monE;

  // Hand model.
  int expSlots = 0;
  int expPending[$];
  bit expClearPending = 1'b1;
  bit expErr = 1'b0;

  typedef struct {
    logic [3:0] card;
    bit         expErrAfter;
    int         expSlotsAfter;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit modelReady();
    return !expClearPending && ((expSlots + expPending.size()) < M_SLOTS) &&
           (expPending.size() < M_DEPTH);
  endfunction

  // What the next blank commits: a full zero fill, or every queued card in order.
  function automatic void queueBlankWrites();
    if (expClearPending) begin
      for (int i = 0; i < M_SLOTS; i++) exp_q.push_back({32'(M_BASE + i), 32'd0});
      expSlots = 0;
      expClearPending = 1'b0;
      expErr = 1'b0;
    end else begin
      for (int j = 0; j < expPending.size(); j++) begin
        exp_q.push_back({32'(M_BASE + expSlots), 32'(expPending[j])});
        expSlots++;
      end
    end
    expPending.delete();
  endfunction

  // Every observed write must be the next expected one.
  always @(negedge clk) begin
    if (!reset && memWEn) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(memWEn), 32'd0);
      end else begin
        monE = exp_q.pop_front();
        check("write_addr", memAddr, monE[63:32]);
        check("write_data", memData, monE[31:0]);
      end
    end
  end

  task automatic deal(input logic [3:0] card);
    bit rdy;
    rdy = modelReady();
    dealValid = 1'b1;
    dealCard  = card;
    #1;
    check("dealReady", 32'(dealReady), 32'(rdy));
    step();
    dealValid = 1'b0;
    if (rdy) begin
      if (card >= 1 && card <= 13) expPending.push_back(int'(card));
      else expErr = 1'b1;
    end
  endtask

  task automatic clearPulse();
    clearReq = 1'b1;
    step();
    clearReq = 1'b0;
    expPending.delete();
    expClearPending = 1'b1;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy || memWEn) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic postChecks();
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check("slotCount", 32'(slotCount), 32'(expSlots));
    check("err", 32'(err), 32'(expErr));
    check("busy_idle", 32'(busy), 32'd0);
    check("dealReady_idle", 32'(dealReady), 32'(modelReady()));
  endtask

  task automatic blank();
    queueBlankWrites();
    screenEnd = 1'b1;
    step();
    screenEnd = 1'b0;
    waitIdle();
    postChecks();
  endtask

  initial begin
    int n;
    int rounds;

    vecs[0] = '{card: 4'd5,  expErrAfter: 1'b0, expSlotsAfter: 1};
    vecs[1] = '{card: 4'd12, expErrAfter: 1'b0, expSlotsAfter: 2};
    vecs[2] = '{card: 4'd0,  expErrAfter: 1'b1, expSlotsAfter: 2};
    vecs[3] = '{card: 4'd14, expErrAfter: 1'b1, expSlotsAfter: 2};
    vecs[4] = '{card: 4'd13, expErrAfter: 1'b1, expSlotsAfter: 3};
    vecs[5] = '{card: 4'd1,  expErrAfter: 1'b1, expSlotsAfter: 4};
    vecs[6] = '{card: 4'd15, expErrAfter: 1'b1, expSlotsAfter: 4};

    // Reset values.
    step(); step();
    check("rst_memWEn", 32'(memWEn), 32'd0);
    check("rst_memAddr", memAddr, 32'd0);
    check("rst_memData", memData, 32'd0);
    check("rst_slotCount", 32'(slotCount), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dealReady", 32'(dealReady), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    step(); step();

    // Post-reset zero fill: one-cycle latency, then seven consecutive writes.
    queueBlankWrites();
    screenEnd = 1'b1;
    step();
    screenEnd = 1'b0;
    check("latency_early", 32'(memWEn), 32'd0);
    step();
    check("latency_first", 32'(memWEn), 32'd1);
    n = 0;
    while (memWEn && n < 20) begin
      n++;
      step();
    end
    check("clear_run_len", 32'(n), 32'd7);
    waitIdle();
    postChecks();

    // Table: single deals committed one per blank, invalid cards only set err.
    for (int i = 0; i < 7; i++) begin
      deal(vecs[i].card);
      if (expPending.size() > 0) blank();
      else step();
      check("vec_err", 32'(err), 32'(vecs[i].expErrAfter));
      check("vec_slots", 32'(slotCount), 32'(vecs[i].expSlotsAfter));
    end
    clearPulse();
    blank();
    check("err_cleared", 32'(err), 32'd0);

    // Full hand across two blanks, with refused extra beats.
    deal(4'd3); deal(4'd4); deal(4'd5); deal(4'd6);
    deal(4'd7);
    blank();
    deal(4'd8); deal(4'd9); deal(4'd10);
    deal(4'd11);
    blank();
    check("full_slots", 32'(slotCount), 32'd7);
    check("full_ready", 32'(dealReady), 32'd0);
    clearPulse();
    blank();

    // Clear arriving during the second write of a three-entry drain.
    deal(4'd2); deal(4'd3); deal(4'd4);
    exp_q.push_back({32'(M_BASE), 32'd2});
    exp_q.push_back({32'(M_BASE + 1), 32'd3});
    screenEnd = 1'b1;
    step();
    screenEnd = 1'b0;
    step();
    step();
    check("drain_second_write", 32'(memWEn), 32'd1);
    clearReq = 1'b1;
    step();
    clearReq = 1'b0;
    check("drain_flushed", 32'(memWEn), 32'd0);
    check("drain_slots", 32'(slotCount), 32'd2);
    check("drain_busy", 32'(busy), 32'd1);
    expSlots = 2;
    expPending.delete();
    expClearPending = 1'b1;
    step();
    check("drain_writes", 32'(exp_q.size()), 32'd0);
    blank();
    check("drain_zero_slots", 32'(slotCount), 32'd0);

    // Deal, clearReq and screenEnd together while waiting for a blank.
    deal(4'd9);
    dealValid = 1'b1;
    dealCard  = 4'd3;
    clearReq  = 1'b1;
    screenEnd = 1'b1;
    #1;
    check("simul_ready", 32'(dealReady), 32'd0);
    expPending.delete();
    expClearPending = 1'b1;
    queueBlankWrites();
    step();
    dealValid = 1'b0;
    clearReq  = 1'b0;
    screenEnd = 1'b0;
    check("simul_state", 32'(dbgState), 32'(CLEAR));
    check("simul_no_write_yet", 32'(memWEn), 32'd0);
    step();
    check("simul_clear_starts", 32'(memWEn), 32'd1);
    waitIdle();
    postChecks();

    // Randomised hands checked against the model.
    for (rounds = 0; rounds < 25; rounds++) begin
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 9) == 0) clearPulse();
        deal(4'($urandom_range(0, 15)));
      end
      if (expSlots == M_SLOTS && $urandom_range(0, 1) == 1) clearPulse();
      if (expClearPending || expPending.size() > 0) blank();
    end

    // Reset in the middle of a drain drops the write at once.
    clearPulse();
    blank();
    deal(4'd6); deal(4'd7);
    exp_q.push_back({32'(M_BASE), 32'd6});
    exp_q.push_back({32'(M_BASE + 1), 32'd7});
    screenEnd = 1'b1;
    step();
    screenEnd = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    check("async_rst_memWEn", 32'(memWEn), 32'd0);
    check("async_rst_slots", 32'(slotCount), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd1);
    exp_q.delete();
    expSlots = 0;
    expPending.delete();
    expClearPending = 1'b1;
    expErr = 1'b0;
    step();
    reset = 1'b0;
    step(); step();
    blank();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
